// File: rtl/mem_req_fifo_if.sv
// Request bus between the MPEG2 core (write side), the FIFO and the DDR3 shim (read side).
// master: the core/shim side driving requests; slave: the FIFO.
interface mem_req_fifo_if;
    logic        mem_req_wr_en;
    logic [1:0]  mem_req_wr_cmd;
    logic [21:0] mem_req_wr_addr;
    logic [63:0] mem_req_wr_dta;
    logic        mem_req_wr_full;
    logic        mem_req_wr_almost_full;
    logic        mem_req_rd_en;
    logic [1:0]  mem_req_rd_cmd;
    logic [21:0] mem_req_rd_addr;
    logic [63:0] mem_req_rd_dta;
    logic        mem_req_rd_valid;

    modport master (
        output mem_req_wr_en, mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_rd_en,
        input  mem_req_wr_full, mem_req_wr_almost_full,
        input  mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid
    );

    modport slave (
        input  mem_req_wr_en, mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_rd_en,
        output mem_req_wr_full, mem_req_wr_almost_full,
        output mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid
    );
endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous memory-request FIFO, core -> DDR3 shim, registered one-cycle pop.
// Optional: define MEM_REQ_FIFO_DROP_NOOP_EN to discard NOOP/REFRESH pushes at the write port.
module mem_req_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned AF_THRESHOLD = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_req_fifo_if.slave         bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]         DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]         AF_LVL    = LW'(AF_THRESHOLD);
    localparam logic [LW-1:0]         LVL_ZERO  = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic                  AF_RST    = (AF_THRESHOLD == 0);

    logic [87:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d, af_q, af_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [87:0]           rd_word_q, rd_word_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  push_req, push_acc, pop_acc;
    logic [87:0]           wr_word;

`ifdef MEM_REQ_FIFO_DROP_NOOP_EN
    // Only READ (2) and WRITE (3) are real requests; NOOP/REFRESH never enter storage.
    assign push_req = bus.mem_req_wr_en & bus.mem_req_wr_cmd[1];
`else
    assign push_req = bus.mem_req_wr_en;
`endif

    assign wr_word  = {bus.mem_req_wr_cmd, bus.mem_req_wr_addr, bus.mem_req_wr_dta};
    // Full/empty decisions use pre-edge state, so a push while full is refused even with a pop.
    assign push_acc = push_req & ~full_q;
    assign pop_acc  = bus.mem_req_rd_en & (level_q != LVL_ZERO);

    // Next-state: pointers, level, flags and the registered pop data.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_word_d   = rd_word_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q | (push_req & full_q);
        underflow_d = underflow_q | (bus.mem_req_rd_en & (level_q == LVL_ZERO));
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_word_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        level_d = level_q + LW'(push_acc) - LW'(pop_acc);
        full_d  = (level_d == DEPTH_LVL);
        af_d    = (level_d >= AF_LVL);
    end

    // Control state register with synchronous reset; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            af_q        <= AF_RST;
            rd_valid_q  <= 1'b0;
            rd_word_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            af_q        <= af_d;
            rd_valid_q  <= rd_valid_d;
            rd_word_q   <= rd_word_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign bus.mem_req_wr_full        = full_q;
    assign bus.mem_req_wr_almost_full = af_q;
    assign bus.mem_req_rd_valid       = rd_valid_q;
    assign bus.mem_req_rd_cmd         = rd_word_q[87:86];
    assign bus.mem_req_rd_addr        = rd_word_q[85:64];
    assign bus.mem_req_rd_dta         = rd_word_q[63:0];
    assign level                      = level_q;
    assign overflow                   = overflow_q;
    assign underflow                  = underflow_q;
endmodule

// File: tb/tb_mem_req_fifo.sv
// Self-checking bench for mem_req_fifo against a queue-based reference model.
module tb_mem_req_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] level;
    logic       overflow, underflow;
    int         total = 0;
    int         bad = 0;

    mem_req_fifo_if bus_if ();

    mem_req_fifo #(.DEPTH_LOG2(4), .AF_THRESHOLD(AF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored {cmd, addr, dta} words plus expected outputs.
    logic [87:0] q[$];
    logic        m_valid;
    logic [87:0] m_rd;
    logic        m_ovf, m_unf;

    function automatic bit stored(input logic [1:0] cmd);
`ifdef MEM_REQ_FIFO_DROP_NOOP_EN
        return cmd >= 2'd2;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle of stimulus, step the model at the edge, sample 1 time unit later.
    task automatic cycle(input logic we, input logic [1:0] cmd, input logic [21:0] addr,
                         input logic [63:0] dta, input logic re);
        bit was_full, was_empty;
        bus_if.mem_req_wr_en   = we;
        bus_if.mem_req_wr_cmd  = cmd;
        bus_if.mem_req_wr_addr = addr;
        bus_if.mem_req_wr_dta  = dta;
        bus_if.mem_req_rd_en   = re;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_valid   = 1'b0;
        if (re && !was_empty) begin
            m_valid = 1'b1;
            m_rd    = q.pop_front();
        end
        if (re && was_empty) m_unf = 1'b1;
        if (we && stored(cmd)) begin
            if (was_full) m_ovf = 1'b1;
            else q.push_back({cmd, addr, dta});
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b0);
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b0);
        rst_n = 1'b1;
        q.delete();
        m_valid = 1'b0;
        m_rd    = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if ({level, bus_if.mem_req_wr_full, bus_if.mem_req_wr_almost_full,
             bus_if.mem_req_rd_valid, overflow, underflow} !== 10'd0) begin
            bad++;
            $display("FAIL reset_flags: got level=%0d full=%b af=%b valid=%b ovf=%b unf=%b want all 0",
                     level, bus_if.mem_req_wr_full, bus_if.mem_req_wr_almost_full,
                     bus_if.mem_req_rd_valid, overflow, underflow);
        end
        total++;
        if ({bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta} !== 88'd0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h want 0",
                     {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta});
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
            total++;
            if (bus_if.mem_req_rd_valid !== 1'b0 || level !== 5'd0) begin
                bad++;
                $display("FAIL empty_pop_%0d: got valid=%b level=%0d want 0/0",
                         i, bus_if.mem_req_rd_valid, level);
            end
        end
        total++;
        if (underflow !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL underflow_sticky: got unf=%b ovf=%b want 1/0", underflow, overflow);
        end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1'b1, 2'd3, 22'h000123, 64'hDEADBEEF_CAFEF00D, 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b0 || level !== 5'd1) begin
            bad++;
            $display("FAIL no_fallthrough: got valid=%b level=%0d want 0/1",
                     bus_if.mem_req_rd_valid, level);
        end
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b1 || bus_if.mem_req_rd_cmd !== 2'd3 ||
            bus_if.mem_req_rd_addr !== 22'h000123 ||
            bus_if.mem_req_rd_dta !== 64'hDEADBEEF_CAFEF00D || level !== 5'd0) begin
            bad++;
            $display("FAIL single_pop: got valid=%b cmd=%0d addr=%h dta=%h level=%0d want 1/3/000123/deadbeefcafef00d/0",
                     bus_if.mem_req_rd_valid, bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr,
                     bus_if.mem_req_rd_dta, level);
        end
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b0 || bus_if.mem_req_rd_addr !== 22'h000123) begin
            bad++;
            $display("FAIL valid_pulse: got valid=%b addr=%h want 0 with held addr 000123",
                     bus_if.mem_req_rd_valid, bus_if.mem_req_rd_addr);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 2'($urandom_range(2, 3)), 22'(i), rnd64(), 1'b0);
            total++;
            if (bus_if.mem_req_wr_almost_full !== (i + 1 >= AF) ||
                bus_if.mem_req_wr_full !== (i + 1 == DEPTH) || level !== 5'(i + 1)) begin
                bad++;
                $display("FAIL fill_%0d: got af=%b full=%b level=%0d want %b/%b/%0d", i,
                         bus_if.mem_req_wr_almost_full, bus_if.mem_req_wr_full, level,
                         i + 1 >= AF, i + 1 == DEPTH, i + 1);
            end
        end
        cycle(1'b1, 2'd2, 22'h3FFFFF, rnd64(), 1'b0);
        total++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            bad++;
            $display("FAIL overflow_push: got ovf=%b level=%0d want 1/16", overflow, level);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
            total++;
            if (bus_if.mem_req_rd_valid !== 1'b1 || bus_if.mem_req_rd_addr !== 22'(i) ||
                {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta} !== m_rd) begin
                bad++;
                $display("FAIL drain_%0d: got valid=%b word=%h want 1/%h", i,
                         bus_if.mem_req_rd_valid,
                         {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta},
                         m_rd);
            end
        end
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b0 || level !== 5'd0) begin
            bad++;
            $display("FAIL drain_end: got valid=%b level=%0d want 0/0",
                     bus_if.mem_req_rd_valid, level);
        end
    endtask

    task automatic test_steady();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'($urandom_range(2, 3)), 22'($urandom), rnd64(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 2'($urandom_range(2, 3)), 22'($urandom), rnd64(), 1'b1);
            total++;
            if (level !== 5'd8 || bus_if.mem_req_rd_valid !== 1'b1 ||
                {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta} !== m_rd) begin
                bad++;
                $display("FAIL steady_%0d: got level=%0d valid=%b word=%h want 8/1/%h", i, level,
                         bus_if.mem_req_rd_valid,
                         {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta},
                         m_rd);
            end
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2'd3, 22'(i + 100), rnd64(), 1'b0);
        cycle(1'b1, 2'd2, 22'h2AAAAA, rnd64(), 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b1 || bus_if.mem_req_rd_addr !== 22'd100 ||
            overflow !== 1'b1 || level !== 5'd15 || bus_if.mem_req_wr_full !== 1'b0) begin
            bad++;
            $display("FAIL full_simul: got valid=%b addr=%0d ovf=%b level=%0d full=%b want 1/100/1/15/0",
                     bus_if.mem_req_rd_valid, bus_if.mem_req_rd_addr, overflow, level,
                     bus_if.mem_req_wr_full);
        end
    endtask

    task automatic test_cmd_filter();
        do_reset();
        cycle(1'b1, 2'd0, 22'h10, rnd64(), 1'b0);
        cycle(1'b1, 2'd1, 22'h10, rnd64(), 1'b0);
        cycle(1'b1, 2'd2, 22'h10, rnd64(), 1'b0);
`ifdef MEM_REQ_FIFO_DROP_NOOP_EN
        total++;
        if (level !== 5'd1) begin
            bad++;
            $display("FAIL filter_level: got %0d want 1", level);
        end
        cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
        total++;
        if (bus_if.mem_req_rd_valid !== 1'b1 || bus_if.mem_req_rd_cmd !== 2'd2 ||
            bus_if.mem_req_rd_addr !== 22'h10) begin
            bad++;
            $display("FAIL filter_pop: got valid=%b cmd=%0d addr=%h want 1/2/10",
                     bus_if.mem_req_rd_valid, bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr);
        end
`else
        total++;
        if (level !== 5'd3) begin
            bad++;
            $display("FAIL filter_level: got %0d want 3", level);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
            total++;
            if (bus_if.mem_req_rd_valid !== 1'b1 || bus_if.mem_req_rd_cmd !== 2'(i) ||
                bus_if.mem_req_rd_addr !== 22'h10) begin
                bad++;
                $display("FAIL filter_pop_%0d: got valid=%b cmd=%0d addr=%h want 1/%0d/10", i,
                         bus_if.mem_req_rd_valid, bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, i);
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // Alternate bias phases so both full and empty regions are exercised.
            int unsigned wp = ((i / 50) % 2 == 0) ? 75 : 30;
            cycle($urandom_range(0, 99) < wp, 2'($urandom), 22'($urandom), rnd64(),
                  $urandom_range(0, 99) < (100 - wp));
            if (i == 200) begin
                rst_n = 1'b0;
                cycle(1'b1, 2'd3, 22'd7, rnd64(), 1'b1);
                rst_n = 1'b1;
                q.delete();
                m_valid = 1'b0;
                m_rd = '0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            total++;
            if (level !== 5'(q.size()) || bus_if.mem_req_rd_valid !== m_valid ||
                {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta} !== m_rd ||
                bus_if.mem_req_wr_full !== (q.size() == DEPTH) ||
                bus_if.mem_req_wr_almost_full !== (q.size() >= AF) ||
                overflow !== m_ovf || underflow !== m_unf) begin
                bad++;
                $display("FAIL random_%0d: got level=%0d valid=%b word=%h full=%b af=%b ovf=%b unf=%b want %0d/%b/%h/%b/%b/%b/%b",
                         i, level, bus_if.mem_req_rd_valid,
                         {bus_if.mem_req_rd_cmd, bus_if.mem_req_rd_addr, bus_if.mem_req_rd_dta},
                         bus_if.mem_req_wr_full, bus_if.mem_req_wr_almost_full, overflow, underflow,
                         q.size(), m_valid, m_rd, q.size() == DEPTH, q.size() >= AF, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        bus_if.mem_req_wr_en   = 1'b0;
        bus_if.mem_req_wr_cmd  = 2'd0;
        bus_if.mem_req_wr_addr = 22'd0;
        bus_if.mem_req_wr_dta  = 64'd0;
        bus_if.mem_req_rd_en   = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_steady();
        test_full_simul();
        test_cmd_filter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
